// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32I funct3 codes,
// FSM state encoding and the width of the optional timeout counter.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TO_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } lsu_state_t;

    // True when the access must not reach memory: misaligned half/word
    // accesses, reserved funct3 codes, or unsigned-load codes used as stores.
    function automatic logic access_bad(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] a);
        logic illegal;
        logic misaligned;
        illegal    = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
        misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                     ((f3[1:0] == 2'b10) && (a != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of the memory word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select followed by extension; unknown codes yield zero.
    always_comb begin
        byte_lane = mem_rdata[8*addr_lo +: 8];
        half_lane = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            F3_B:    rdata = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    rdata = {{16{half_lane[15]}}, half_lane};
            F3_W:    rdata = mem_rdata;
            F3_BU:   rdata = {24'h0, byte_lane};
            F3_HU:   rdata = {16'h0, half_lane};
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator: latches a pipeline access, issues it to the
// word-organised data memory over a req/ready handshake and returns a
// one-cycle response. Optional macro LSU_TIMEOUT_EN adds a REQ-state
// watchdog that faults after TIMEOUT_CYCLES cycles without mem_ready.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t        state, next_state;
    logic              lat_we;
    logic [2:0]        lat_f3;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       rdata_q;
    logic              fault_q;
    logic [31:0]       load_data;
    logic              timeout_hit;
    logic              req_bad;
    logic [3:0]        be_w;
    logic [31:0]       wdata_w;

    assign req_bad = access_bad(req_we, req_funct3, req_addr[1:0]);

    lsu_load_align u_align (
        .funct3    (lat_f3),
        .addr_lo   (lat_addr[1:0]),
        .mem_rdata (mem_rdata),
        .rdata     (load_data)
    );

`ifdef LSU_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt;

    // Watchdog counter: zero outside REQ, counts REQ cycles without ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (state != ST_REQ)
            to_cnt <= '0;
        else if (!mem_ready)
            to_cnt <= to_cnt + 1'b1;
    end

    assign timeout_hit = (state == ST_REQ) && !mem_ready && (to_cnt == TO_LIMIT);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TO_LIMIT;
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic and the externally visible handshake/response outputs.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        rsp_valid  = 1'b0;
        fault      = 1'b0;
        rsp_rdata  = 32'h0;
        case (state)
            ST_IDLE: begin
                stall = req_valid;
                if (req_valid)
                    next_state = req_bad ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                stall = 1'b1;
                if (mem_ready || timeout_hit)
                    next_state = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid  = 1'b1;
                fault      = fault_q;
                rsp_rdata  = rdata_q;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Byte enables and lane-replicated store data from the latched access.
    always_comb begin
        case (lat_f3[1:0])
            2'b00: begin
                be_w    = 4'b0001 << lat_addr[1:0];
                wdata_w = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                be_w    = 4'b0011 << {lat_addr[1], 1'b0};
                wdata_w = {2{lat_wdata[15:0]}};
            end
            default: begin
                be_w    = 4'b1111;
                wdata_w = lat_wdata;
            end
        endcase
    end

    // Memory-side outputs are only driven while a request is outstanding.
    always_comb begin
        mem_req   = (state == ST_REQ);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        if (state == ST_REQ) begin
            mem_we    = lat_we;
            mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
            mem_be    = be_w;
            mem_wdata = wdata_w;
        end
    end

    // Access latch and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_f3    <= 3'b000;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
            rdata_q   <= 32'h0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_f3    <= req_funct3;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        rdata_q   <= 32'h0;
                        fault_q   <= req_bad;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        rdata_q <= lat_we ? 32'h0 : load_data;
                        fault_q <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= 32'h0;
                        fault_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed cases plus randomized
// accesses compared against an arithmetic model of the load/store rules.
// Define LSU_TIMEOUT_EN on both DUT and bench to exercise the watchdog.
module tb_lsu_mem_master;

    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int testsRun;
    int testsFailed;

    lsu_mem_master #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Access size in bytes, 0 for reserved codes.
    function automatic int accSize(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit accFault(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        int s;
        s = accSize(f3);
        if (s == 0) return 1'b1;
        if (we && (f3 > 3'd2)) return 1'b1;
        return (addr % s) != 0;
    endfunction

    function automatic logic [3:0] expBe(input logic [2:0] f3, input logic [31:0] addr);
        int s;
        s = accSize(f3);
        return 4'((((1 << s) - 1) << (addr % 4)));
    endfunction

    function automatic logic [31:0] expWdata(input logic [2:0] f3, input logic [31:0] wd);
        case (accSize(f3))
            1:       return (wd & 32'hFF) * 32'h01010101;
            2:       return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] expRdata(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        int          bits;
        logic [31:0] v;
        logic [31:0] mask;
        bits = accSize(f3) * 8;
        v    = word >> ((addr % 4) * 8);
        if (bits < 32) begin
            mask = (32'h1 << bits) - 1;
            v    = v & mask;
            if (!f3[2] && v[bits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // One complete access: drive the request, play memory with 'waits' wait
    // states, and compare handshake, memory-side fields and response.
    task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int waits,
                                 input logic [31:0] word, input string tag);
        bit          expFault;
        bit          badAcc;
        int          expLat;
        int          reqCycles;
        int          protoErrs;
        bit          done;
        bit          firstReq;
        logic [31:0] expData;
        badAcc   = accFault(we, f3, addr);
        expFault = badAcc;
        expLat   = badAcc ? 1 : waits + 2;
`ifdef LSU_TIMEOUT_EN
        if (!badAcc && waits >= TB_TIMEOUT) begin
            expFault = 1'b1;
            expLat   = TB_TIMEOUT + 1;
        end
`endif
        expData = (expFault || we) ? 32'h0 : expRdata(f3, addr, word);

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        done       = 1'b0;
        firstReq   = 1'b1;
        reqCycles  = 0;
        protoErrs  = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (stall !== (c < expLat)) protoErrs++;
            if (mem_req !== (!badAcc && c >= 1 && c < expLat)) protoErrs++;
            if (mem_req === 1'b1) begin
                reqCycles++;
                if (firstReq) begin
                    checkOutput({tag, " mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
                    checkOutput({tag, " mem_be"}, {28'h0, mem_be}, {28'h0, expBe(f3, addr)});
                    checkOutput({tag, " mem_we"}, {31'h0, mem_we}, {31'h0, we});
                    if (we) checkOutput({tag, " mem_wdata"}, mem_wdata, expWdata(f3, wdata));
                    firstReq = 1'b0;
                end
                mem_ready = (reqCycles > waits);
                mem_rdata = mem_ready ? word : $urandom;
            end else begin
                mem_ready = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                checkOutput({tag, " latency"}, c, expLat);
                checkOutput({tag, " fault"}, {31'h0, fault}, {31'h0, expFault});
                checkOutput({tag, " rdata"}, rsp_rdata, expData);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (done) req_valid = 1'b0;
        end
        if (!done) checkOutput({tag, " no response"}, 32'h0, 32'h1);
        checkOutput({tag, " handshake"}, protoErrs, 0);
        req_valid = 1'b0;
    endtask

    initial begin
        int stuckErrs;
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_funct3  = 3'b000;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        mem_ready   = 1'b0;
        mem_rdata   = 32'h0;

        #2;
        checkOutput("reset ctl", {27'h0, stall, rsp_valid, fault, mem_req, mem_we}, 32'h0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset mem_be", {28'h0, mem_be}, 32'h0);
        checkOutput("reset mem_wdata", mem_wdata, 32'h0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 32'h0, "sb");
        applyStimulus(1'b0, 3'b000, 32'h202, 32'h0, 0, 32'h80FF7F01, "lb");
        applyStimulus(1'b0, 3'b100, 32'h203, 32'h0, 1, 32'h80FF7F01, "lbu");
        applyStimulus(1'b0, 3'b001, 32'h202, 32'h0, 0, 32'h80FF7F01, "lh");
        applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 5, 32'hDEADBEEF, "lw wait");
        applyStimulus(1'b0, 3'b010, 32'h41, 32'h0, 0, 32'h12345678, "lw misaligned");
        applyStimulus(1'b0, 3'b011, 32'h40, 32'h0, 0, 32'h12345678, "f3 011");
        applyStimulus(1'b1, 3'b001, 32'h206, 32'h0000BEEF, 2, 32'h0, "sh hi");
        applyStimulus(1'b1, 3'b100, 32'h200, 32'h11, 0, 32'h0, "store bu");

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                          $urandom, $urandom_range(0, 3), $urandom, "random");
        end

        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre-reset mem_req", {31'h0, mem_req}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("async reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b0;
        applyStimulus(1'b0, 3'b010, 32'h44, 32'h0, 0, 32'hCAFEF00D, "lw after reset");

`ifdef LSU_TIMEOUT_EN
        applyStimulus(1'b0, 3'b010, 32'h48, 32'h0, 1000, 32'h0, "timeout");
`else
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h48;
        stuckErrs  = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (stall !== 1'b1 || rsp_valid !== 1'b0) stuckErrs++;
            if (c > 0 && mem_req !== 1'b1) stuckErrs++;
        end
        checkOutput("stuck stall", stuckErrs, 0);
        rst = 1'b1;
        #2;
        req_valid = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'b101, 32'h4A, 32'h0, 0, 32'h9ABC0000, "lhu after stuck");
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
